uart_send_ext: RTL and testbench
================================

UART_SEND_EXT -- requirements
Module: uart_send_ext

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, FIFO entries; power of 2, at least 2.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port sys_rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port tx_valid, input, 1 bit: tx_data holds a word to send.
REQ-010 SHALL have port tx_data, input, DATA_BITS bits: word to send, LSB transmitted first.
REQ-011 SHALL have port tx_ready, output, 1 bit: a word is accepted on any cycle where tx_valid and tx_ready are both high.
REQ-012 SHALL have port uart_tx_busy, output, 1 bit: high while a frame is in flight or any word is queued.
REQ-013 SHALL have port uart_txd, output, 1 bit: registered serial line; idle level is 1.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of queued words, excluding the word in the shifter.

Function
REQ-015 SHALL compute BPS_CNT = CLK_FREQ/UART_BPS using integer division; every bit, stop bits included, SHALL last exactly BPS_CNT cycles.
REQ-016 SHALL fail elaboration if BPS_CNT < 2, DATA_BITS is outside 5..9, PARITY > 2, or STOP_BITS is not 1 or 2.
REQ-017 SHALL send each frame as: start bit 0; DATA_BITS data bits, LSB first; one parity bit if PARITY != 0; STOP_BITS stop bits of 1.
REQ-018 SHALL compute parity as even = XOR of the data bits and odd = the inverse of that XOR.
REQ-019 SHALL implement an FSM with states IDLE, START, DATA, PAR, STOP:
- IDLE -> START when a word is available;
- START -> DATA after 1 bit time;
- DATA -> PAR, or -> STOP if PARITY=0, after DATA_BITS bit times;
- PAR -> STOP after 1 bit time;
- STOP -> START if a word is queued, else -> IDLE, after STOP_BITS bit times.
REQ-020 SHALL, when idle, drive the start bit on uart_txd starting on the cycle after the accepting handshake (latency 1).
REQ-021 SHALL, when back-to-back, drive the next start bit on the cycle immediately after the last stop-bit cycle, with zero idle gap.
REQ-022 SHALL copy the word into the shifter when entering START; later changes on tx_data SHALL NOT affect a frame in flight.
REQ-023 SHALL drive uart_tx_busy = (state != IDLE) | (fifo_level != 0); it SHALL fall on the cycle after the final stop-bit cycle when nothing is queued.
REQ-024 SHALL ignore tx_data whenever tx_valid is low; tx_valid high while tx_ready is low SHALL neither lose nor duplicate data.

Reset
REQ-025 SHALL, on sys_rst high at a clock edge, set on the next edge: uart_txd=1, tx_ready=1, uart_tx_busy=0, fifo_level=0, state=IDLE, bit and baud counters 0.
REQ-026 SHALL, on reset mid-frame, abandon the frame and flush all queued words; uart_txd SHALL return to 1 on the next edge.
REQ-027 SHALL ignore tx_valid during any cycle in which sys_rst is high.

Configuration
REQ-028 SHALL use macro UART_SEND_FIFO_EN, defined: queue words in a FIFO_DEPTH-entry FIFO; tx_ready = !full.
REQ-029 SHALL use tx_ready as a registered flag when UART_SEND_FIFO_EN is defined; a push in the same cycle as a pop from a full FIFO SHALL be refused.
REQ-030 SHALL, with UART_SEND_FIFO_EN undefined, use a single holding register in place of the FIFO:
- tx_ready = holding register empty;
- fifo_level is 0 or 1;
- FIFO_DEPTH is ignored.

Structure
REQ-031 SHALL place the state enum, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the BPS_CNT helper function in shared package uart_pkg.
REQ-032 SHALL implement the FIFO as one sub-module uart_tx_fifo (synchronous FIFO, show-ahead read), instantiated only under UART_SEND_FIFO_EN.

Verification
Bench uses CLK_FREQ=1000000 and UART_BPS=100000, giving BPS_CNT=10.
REQ-033 SHALL verify 8N1: send 0xA5 -> uart_txd = 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; uart_tx_busy low at cycle 101 after the handshake.
REQ-034 SHALL verify DATA_BITS=7: send 0x55 with PARITY=2 -> parity bit 0; same word with PARITY=1 -> parity bit 1; frame length 100 cycles.
REQ-035 SHALL verify STOP_BITS=2 back-to-back: send 0x00 then 0xFF -> 20 cycles of stop level, then the second start bit with no gap.
REQ-036 SHALL verify FIFO_EN with FIFO_DEPTH=16: hold tx_valid for 20 words during the first frame -> 17 accepted, tx_ready low at fifo_level=16, all 20 words serialised in order with no loss.
REQ-037 SHALL verify reset mid-frame: assert sys_rst during data bit 3 -> next edge uart_txd=1, fifo_level=0, uart_tx_busy=0; the next push sends a complete fresh frame.
REQ-038 SHALL verify with FIFO_EN undefined: push 3 words -> 2 accepted, the third stalls with tx_ready low until the first frame's start-to-shifter handoff.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-mode constants and helper functions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit; integer division truncates.
    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Parity over up to 9 data bits; zero-extension does not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the UART shifter. ready is a
// registered not-full flag, so a push while full is refused even if a
// pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   valid,
    output logic                   ready,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             ready_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s   = push & ready_r;
    assign do_pop_s    = pop & (count_r != {(AW+1){1'b0}});
    assign count_nxt_s = count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);

    // Pointer, occupancy and registered not-full bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s != (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents need no reset because count_r guards reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign valid = (count_r != {(AW+1){1'b0}});
    assign ready = ready_r;
    assign level = count_r;

endmodule

// File: rtl/uart_send_ext.sv
// UART transmitter with start/data/parity/stop framing and a word queue.
// Build option: define UART_SEND_FIFO_EN to queue words in a FIFO_DEPTH
// FIFO (uart_tx_fifo); otherwise a single holding register is used.
// A word arriving while the line is idle goes straight into the shifter,
// so the start bit appears on the cycle after the handshake.
module uart_send_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          uart_tx_busy,
    output logic                          uart_txd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;
    localparam int CW      = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;

    if ((BPS_CNT < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) ||
        (PARITY > 2) || ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_bad_cfg
        $fatal(1, "uart_send_ext: illegal parameter combination");
    end

    uart_state_e          state_r;
    uart_state_e          state_nxt_s;
    logic [CW-1:0]        baud_r;
    logic [3:0]           bit_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic                 txd_r;
    logic                 busy_r;
    logic                 bit_end_s;
    logic                 take_s;
    logic                 avail_s;
    logic                 push_s;
    logic                 q_push_s;
    logic                 pop_s;
    logic                 q_valid_s;
    logic                 q_ready_s;
    logic [DATA_BITS-1:0] q_head_s;
    logic [DATA_BITS-1:0] word_s;
    logic [LW-1:0]        q_level_s;
    logic [LW-1:0]        lvl_nxt_s;

    assign push_s    = tx_valid & q_ready_s & ~sys_rst;
    assign avail_s   = q_valid_s | push_s;
    assign word_s    = q_valid_s ? q_head_s : tx_data;
    assign pop_s     = take_s & q_valid_s;
    assign q_push_s  = push_s & ~(take_s & ~q_valid_s);
    assign lvl_nxt_s = q_level_s + LW'(q_push_s) - LW'(pop_s);
    assign bit_end_s = (baud_r == CW'(BPS_CNT - 1));

`ifdef UART_SEND_FIFO_EN
    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (q_push_s),
        .push_data (tx_data),
        .pop       (pop_s),
        .head      (q_head_s),
        .valid     (q_valid_s),
        .ready     (q_ready_s),
        .level     (q_level_s)
    );
`else
    logic                 hold_valid_r;
    logic [DATA_BITS-1:0] hold_data_r;

    // Single-entry holding register used in place of the FIFO.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= {DATA_BITS{1'b0}};
        end else if (q_push_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= tx_data;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    assign q_valid_s = hold_valid_r;
    assign q_head_s  = hold_data_r;
    assign q_ready_s = ~hold_valid_r;
    assign q_level_s = {{(LW-1){1'b0}}, hold_valid_r};
`endif

    // Frame sequencing: next state and when the shifter takes a new word.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (avail_s) begin
                    state_nxt_s = ST_START;
                    take_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_r == 4'(DATA_BITS - 1))) begin
                    if (PARITY != PAR_NONE) begin
                        state_nxt_s = ST_PAR;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (bit_end_s && (bit_r == 4'(STOP_BITS - 1))) begin
                    if (avail_s) begin
                        state_nxt_s = ST_START;
                        take_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, shifter and registered line/busy outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            baud_r  <= {CW{1'b0}};
            bit_r   <= 4'd0;
            shift_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE) || (lvl_nxt_s != {LW{1'b0}});
            if (take_s) begin
                shift_r <= word_s;
                par_r   <= parity_bit(9'(word_s), (PARITY == PAR_ODD));
                baud_r  <= {CW{1'b0}};
                bit_r   <= 4'd0;
                txd_r   <= 1'b0;
            end else if (state_r == ST_IDLE) begin
                baud_r <= {CW{1'b0}};
                bit_r  <= 4'd0;
                txd_r  <= 1'b1;
            end else if (!bit_end_s) begin
                baud_r <= baud_r + CW'(1);
            end else begin
                baud_r <= {CW{1'b0}};
                case (state_r)
                    ST_START: begin
                        bit_r <= 4'd0;
                        txd_r <= shift_r[0];
                    end
                    ST_DATA: begin
                        if (bit_r == 4'(DATA_BITS - 1)) begin
                            bit_r <= 4'd0;
                            txd_r <= (PARITY != PAR_NONE) ? par_r : 1'b1;
                        end else begin
                            bit_r   <= bit_r + 4'd1;
                            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
                            txd_r   <= shift_r[1];
                        end
                    end
                    ST_PAR: begin
                        bit_r <= 4'd0;
                        txd_r <= 1'b1;
                    end
                    ST_STOP: begin
                        if (bit_r == 4'(STOP_BITS - 1)) begin
                            bit_r <= 4'd0;
                        end else begin
                            bit_r <= bit_r + 4'd1;
                        end
                        txd_r <= 1'b1;
                    end
                    default: begin
                        bit_r <= 4'd0;
                        txd_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_ready     = q_ready_s;
    assign uart_tx_busy = busy_r;
    assign uart_txd     = txd_r;
    assign fifo_level   = q_level_s;

endmodule

// File: tb/tb_uart_send_ext.sv
// Self-checking bench for uart_send_ext. Instance u_d0 (8N1) is tracked
// every cycle by a waveform-queue model; u_d1/u_d2 (7E1/7O1) and u_d3
// (8N2) are checked against hand-computed frames.
module tb_uart_send_ext;
    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BPS      = 10;
`ifdef UART_SEND_FIFO_EN
    localparam int CAP = 16;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       v0;
    logic [7:0] dat0;
    logic       vb;
    logic [7:0] datb;
    logic       rdy0, busy0, txd0;
    logic [4:0] lvl0;
    logic       rdy1, busy1, txd1;
    logic [4:0] lvl1;
    logic       rdy2, busy2, txd2;
    logic [4:0] lvl2;
    logic       rdy3, busy3, txd3;
    logic [4:0] lvl3;

    int checks   = 0;
    int failures = 0;

    bit         m_frame[$];
    logic [7:0] m_q[$];
    bit         m_ready;

    always #5 clk = ~clk;

    uart_send_ext #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(16)) u_d0 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(v0), .tx_data(dat0), .tx_ready(rdy0),
        .uart_tx_busy(busy0), .uart_txd(txd0), .fifo_level(lvl0));
    uart_send_ext #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(16)) u_d1 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(vb), .tx_data(datb[6:0]), .tx_ready(rdy1),
        .uart_tx_busy(busy1), .uart_txd(txd1), .fifo_level(lvl1));
    uart_send_ext #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(16)) u_d2 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(vb), .tx_data(datb[6:0]), .tx_ready(rdy2),
        .uart_tx_busy(busy2), .uart_txd(txd2), .fifo_level(lvl2));
    uart_send_ext #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(2), .FIFO_DEPTH(16)) u_d3 (
        .sys_clk(clk), .sys_rst(rst), .tx_valid(vb), .tx_data(datb), .tx_ready(rdy3),
        .uart_tx_busy(busy3), .uart_txd(txd3), .fifo_level(lvl3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Expand one 8N1 word into its per-cycle line levels.
    function automatic void expand(input logic [7:0] w);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < BPS; c++) m_frame.push_back(bits[i]);
        end
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        bit acc;
        bit used;
        if (rst) begin
            m_frame.delete();
            m_q.delete();
            m_ready = 1'b1;
        end else begin
            acc  = v0 && m_ready;
            used = 1'b0;
            if (m_frame.size() > 0) void'(m_frame.pop_front());
            if (m_frame.size() == 0) begin
                if (m_q.size() > 0) begin
                    expand(m_q.pop_front());
                end else if (acc) begin
                    expand(dat0);
                    used = 1'b1;
                end
            end
            if (acc && !used) m_q.push_back(dat0);
            m_ready = (m_q.size() < CAP);
        end
    endtask

    // One clock: update the model at the edge, compare u_d0 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("d0_txd", txd0, (m_frame.size() > 0) ? m_frame[0] : 1'b1);
        chk("d0_busy", busy0, (m_frame.size() > 0) || (m_q.size() > 0));
        chk("d0_level", lvl0, m_q.size());
        chk("d0_ready", rdy0, m_ready);
    endtask

    function automatic logic [7:0] word_of(input int k);
        return 8'(k * 37 + 11);
    endfunction

    int  a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int  e7_bits [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int  o7_bits [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    int  n_words, acc_n, early, acc_j, stop_ones;
    bit  hs;

    initial begin
        rst = 1'b1; v0 = 1'b0; dat0 = 8'h00; vb = 1'b0; datb = 8'h00;
        tick(); tick();
        chk("rst_txd0", txd0, 1'b1);  chk("rst_ready0", rdy0, 1'b1);
        chk("rst_busy0", busy0, 1'b0); chk("rst_level0", lvl0, 5'd0);
        chk("rst_txd1", txd1, 1'b1);  chk("rst_ready1", rdy1, 1'b1);
        chk("rst_busy2", busy2, 1'b0); chk("rst_level2", lvl2, 5'd0);
        chk("rst_txd3", txd3, 1'b1);  chk("rst_ready3", rdy3, 1'b1);
        chk("rst_busy3", busy3, 1'b0); chk("rst_level3", lvl3, 5'd0);
        chk("rst_busy1", busy1, 1'b0); chk("rst_level1", lvl1, 5'd0);
        chk("rst_txd2", txd2, 1'b1);  chk("rst_ready2", rdy2, 1'b1);
        rst = 1'b0;
        tick();

        // 8N1 single word 0xA5; tx_data changes after the handshake.
        dat0 = 8'hA5; v0 = 1'b1;
        tick();
        v0 = 1'b0; dat0 = 8'h5A;
        chk("a5_start_now", txd0, 1'b0);
        for (int j = 1; j <= 105; j++) begin
            tick();
            if ((j % 10) == 5 && j < 100) chk("a5_bit", txd0, a5_bits[j / 10]);
            if (j == 9)   chk("a5_start_len", txd0, 1'b0);
            if (j == 99)  chk("a5_busy_last", busy0, 1'b1);
            if (j == 100) chk("a5_busy_fall", busy0, 1'b0);
        end

        // Queue fill with tx_valid held high through the first frame.
        n_words = (CAP == 16) ? 20 : 3;
        acc_n = 0; early = 0; acc_j = -1;
        v0 = 1'b1; dat0 = word_of(0);
        for (int j = 0; j < 3000 && acc_n < n_words; j++) begin
            hs = v0 && rdy0;
            tick();
            if (hs) begin
                if (j < 100) early++;
                if (acc_n == CAP + 1) acc_j = j;
                acc_n++;
                if (acc_n < n_words) dat0 = word_of(acc_n);
                else begin v0 = 1'b0; dat0 = 8'h00; end
            end
            if (j == CAP) begin
                chk("full_ready", rdy0, 1'b0);
                chk("full_level", lvl0, CAP);
            end
        end
        v0 = 1'b0;
        chk("acc_total", acc_n, n_words);
        chk("acc_first_frame", early, CAP + 1);
        chk("acc_resume_edge", acc_j, 101);
        for (int j = 0; j < 2500 && (m_frame.size() > 0 || m_q.size() > 0); j++) tick();
        tick();
        chk("drain_busy", busy0, 1'b0);
        chk("drain_level", lvl0, 5'd0);

        // Reset during data bit 3 with another word queued.
        dat0 = 8'hC3; v0 = 1'b1;
        tick();
        dat0 = 8'h3E;
        tick();
        v0 = 1'b0;
        for (int j = 2; j <= 45; j++) tick();
        rst = 1'b1; v0 = 1'b1; dat0 = 8'h99;
        tick();
        chk("mid_rst_txd", txd0, 1'b1);
        chk("mid_rst_level", lvl0, 5'd0);
        chk("mid_rst_busy", busy0, 1'b0);
        rst = 1'b0; v0 = 1'b0;
        tick();
        chk("post_rst_idle_txd", txd0, 1'b1);
        dat0 = 8'h3C; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        chk("fresh_start", txd0, 1'b0);
        for (int j = 1; j <= 105; j++) begin
            tick();
            if (j == 25) chk("fresh_bit1", txd0, 1'b0);
            if (j == 35) chk("fresh_bit2", txd0, 1'b1);
            if (j == 100) chk("fresh_busy_fall", busy0, 1'b0);
        end

        // 7E1 / 7O1 frames of 0x55.
        datb = 8'h55; vb = 1'b1;
        tick();
        vb = 1'b0; datb = 8'h2A;
        for (int j = 0; j <= 120; j++) begin
            if (j > 0) tick();
            if ((j % 10) == 5 && j < 100) begin
                chk("e7_bit", txd1, e7_bits[j / 10]);
                chk("o7_bit", txd2, o7_bits[j / 10]);
            end
            if (j == 99) begin
                chk("e7_busy_last", busy1, 1'b1);
                chk("o7_busy_last", busy2, 1'b1);
            end
            if (j == 100) begin
                chk("e7_busy_fall", busy1, 1'b0);
                chk("o7_busy_fall", busy2, 1'b0);
            end
        end

        // 8N2 back-to-back 0x00 then 0xFF.
        datb = 8'h00; vb = 1'b1;
        tick();
        datb = 8'hFF;
        tick();
        vb = 1'b0; datb = 8'h00;
        stop_ones = 0;
        for (int j = 2; j <= 230; j++) begin
            tick();
            if (j >= 90 && j <= 109 && txd3 === 1'b1) stop_ones++;
            if (j == 89)  chk("n2_last_data", txd3, 1'b0);
            if (j == 109) chk("n2_busy_mid", busy3, 1'b1);
            if (j == 110) chk("n2_second_start", txd3, 1'b0);
            if (j == 119) chk("n2_second_start_end", txd3, 1'b0);
            if (j == 120) chk("n2_second_data0", txd3, 1'b1);
            if (j == 219) chk("n2_busy_last", busy3, 1'b1);
            if (j == 220) chk("n2_busy_fall", busy3, 1'b0);
        end
        chk("n2_stop_cycles", stop_ones, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
